// File: rtl/bsg_pair_gather_pkg.sv
// Shared types for bsg_pair_gather: FSM state encoding.
package bsg_pair_gather_pkg;

  typedef enum logic [1:0] {
    eEmpty    = 2'd0,
    eHalf     = 2'd1,
    eFull     = 2'd2,
    eFullHalf = 2'd3
  } bsg_pair_gather_state_e;

endpackage

// File: rtl/bsg_pair_gather.sv
// Gathers two consecutive words into a {second, first} pair plus a swap flag for bsg_swap.
// Optional slot-mismatch detection enabled by defining BSG_PAIR_GATHER_SLOT_CHECK_EN.
module bsg_pair_gather
  import bsg_pair_gather_pkg::*;
#(
  parameter int unsigned width_p = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   slot_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [2*width_p-1:0]   data_o,
  output logic                   swap_o,
  input  logic                   yumi_i,
  output logic                   error_o
);

  bsg_pair_gather_state_e state_q, state_d;
  logic [width_p-1:0]     partial_data_q, partial_data_d;
  logic                   partial_slot_q, partial_slot_d;
  logic [2*width_p-1:0]   pair_data_q, pair_data_d;
  logic                   pair_swap_q, pair_swap_d;
  logic                   accept;
  logic                   pair_form;

  // A held pair plus a partial word fills all storage; only a yumi frees a slot.
  assign ready_o = (state_q != eFullHalf) | yumi_i;
  assign accept  = v_i & ready_o;

  always_comb begin
    state_d        = state_q;
    partial_data_d = partial_data_q;
    partial_slot_d = partial_slot_q;
    pair_data_d    = pair_data_q;
    pair_swap_d    = pair_swap_q;
    pair_form      = 1'b0;
    case (state_q)
      eEmpty: begin
        if (accept) begin
          state_d        = eHalf;
          partial_data_d = data_i;
          partial_slot_d = slot_i;
        end
      end
      eHalf: begin
        if (accept) begin
          state_d   = eFull;
          pair_form = 1'b1;
        end
      end
      eFull: begin
        if (accept) begin
          partial_data_d = data_i;
          partial_slot_d = slot_i;
        end
        if (yumi_i) state_d = accept ? eHalf : eEmpty;
        else        state_d = accept ? eFullHalf : eFull;
      end
      eFullHalf: begin
        if (yumi_i) begin
          state_d   = accept ? eFull : eHalf;
          pair_form = accept;
        end
      end
      default: state_d = eEmpty;
    endcase
    if (pair_form) begin
      pair_data_d = {data_i, partial_data_q};
      pair_swap_d = partial_slot_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= eEmpty;
      partial_data_q <= '0;
      partial_slot_q <= 1'b0;
      pair_data_q    <= '0;
      pair_swap_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      partial_data_q <= partial_data_d;
      partial_slot_q <= partial_slot_d;
      pair_data_q    <= pair_data_d;
      pair_swap_q    <= pair_swap_d;
    end
  end

`ifdef BSG_PAIR_GATHER_SLOT_CHECK_EN
  logic error_q, error_d;

  // Sticky: a pair whose two words claim the same slot.
  always_comb begin
    error_d = error_q | (pair_form & (slot_i == partial_slot_q));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) error_q <= 1'b0;
    else         error_q <= error_d;
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign v_o    = (state_q == eFull) | (state_q == eFullHalf);
  assign data_o = pair_data_q;
  assign swap_o = pair_swap_q;

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
`endif

endmodule

// File: tb/tb_bsg_pair_gather.sv
// Scoreboard bench for bsg_pair_gather: stimulus pushes expected pairs, a monitor pops them.
module tb_bsg_pair_gather;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           reset_i;
  logic           v_i;
  logic [W-1:0]   data_i;
  logic           slot_i;
  logic           ready_o;
  logic           v_o;
  logic [2*W-1:0] data_o;
  logic           swap_o;
  logic           yumi_i;
  logic           error_o;

  bsg_pair_gather #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .slot_i  (slot_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .swap_o  (swap_o),
    .yumi_i  (yumi_i),
    .error_o (error_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*W-1:0] data;
    logic           swap;
  } pair_t;

  pair_t        exp_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  logic         have_half = 1'b0;
  logic [W-1:0] half_d;
  logic         half_s;
  logic         exp_err = 1'b0;
  logic         err_model;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: every two accepted words make a {second, first} pair.
  task automatic model_accept(input logic [W-1:0] d, input logic s);
    pair_t p;
    if (have_half) begin
      p.data = {d, half_d};
      p.swap = half_s;
      exp_q.push_back(p);
      if (s == half_s) exp_err = 1'b1;
      have_half = 1'b0;
    end else begin
      half_d    = d;
      half_s    = s;
      have_half = 1'b1;
    end
  endtask

  // One cycle: drive at negedge, yumi only when a pair is presented.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic s, input logic y);
    @(negedge clk);
    v_i    = v;
    data_i = d;
    slot_i = s;
    yumi_i = y & v_o;
    #1;
    if (v_i && ready_o) model_accept(d, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    @(negedge clk);
    exp_q.delete();
    have_half = 1'b0;
    exp_err   = 1'b0;
    reset_i   = 1'b0;
    #1;
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next posedge.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_i && v_o && yumi_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL pair_unexpected: got %h expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("pair_data", data_o, e.data);
          chk("pair_swap", 64'(swap_o), 64'(e.swap));
        end
      end
    end
  end

  initial begin
    logic [2*W-1:0] swapped;
    logic           s;
    int             guard;
    reset_i = 1'b1;
    v_i     = 1'b0;
    data_i  = '0;
    slot_i  = 1'b0;
    yumi_i  = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    chk("reset_v_o", 64'(v_o), 64'd0);
    chk("reset_data_o", data_o, 64'd0);
    chk("reset_swap_o", 64'(swap_o), 64'd0);
    chk("reset_error_o", 64'(error_o), 64'd0);
    chk("reset_ready_o", 64'(ready_o), 64'd1);

    // 1: in-order pair, visible one cycle after the second word
    cyc(1'b1, 32'h11111111, 1'b0, 1'b1);
    cyc(1'b1, 32'h22222222, 1'b1, 1'b1);
    chk("t1_no_early_v", 64'(v_o), 64'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t1_v_o", 64'(v_o), 64'd1);
    chk("t1_data_o", data_o, 64'h22222222_11111111);
    chk("t1_swap_o", 64'(swap_o), 64'd0);

    // 2: reversed slot order sets swap
    cyc(1'b1, 32'hAAAA0000, 1'b1, 1'b1);
    cyc(1'b1, 32'h0000BBBB, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t2_data_o", data_o, 64'h0000BBBB_AAAA0000);
    chk("t2_swap_o", 64'(swap_o), 64'd1);
    swapped = swap_o ? {data_o[W-1:0], data_o[2*W-1:W]} : data_o;
    chk("t2_after_swap", swapped, 64'hAAAA0000_0000BBBB);

    // 3: backpressure fills eFullHalf; yumi reopens ready in the same cycle
    cyc(1'b1, 32'h00000031, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000032, 1'b1, 1'b0);
    cyc(1'b1, 32'h00000033, 1'b0, 1'b0);
    chk("t3_third_ready", 64'(ready_o), 64'd1);
    cyc(1'b1, 32'h00000034, 1'b1, 1'b0);
    chk("t3_full_ready0", 64'(ready_o), 64'd0);
    chk("t3_held_data", data_o, 64'h00000032_00000031);
    cyc(1'b1, 32'h00000034, 1'b1, 1'b0);
    chk("t3_still_ready0", 64'(ready_o), 64'd0);
    cyc(1'b1, 32'h00000034, 1'b1, 1'b1);
    chk("t3_yumi_ready1", 64'(ready_o), 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t3_second_pair_v", 64'(v_o), 64'd1);
    chk("t3_second_pair", data_o, 64'h00000034_00000033);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_drained_v", 64'(v_o), 64'd0);

    // 4: reset in eFullHalf drops the pair and the partial word
    cyc(1'b1, 32'h00000041, 1'b0, 1'b0);
    cyc(1'b1, 32'h00000042, 1'b1, 1'b0);
    cyc(1'b1, 32'h00000043, 1'b0, 1'b0);
    do_reset();
    chk("t4_v_o", 64'(v_o), 64'd0);
    chk("t4_ready_o", 64'(ready_o), 64'd1);
    cyc(1'b1, 32'h00000051, 1'b1, 1'b1);
    cyc(1'b1, 32'h00000052, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t4_fresh_pair", data_o, 64'h00000052_00000051);
    chk("t4_fresh_swap", 64'(swap_o), 64'd1);

    // 5: two slot-0 words in one pair
    cyc(1'b1, 32'h00000061, 1'b0, 1'b1);
    cyc(1'b1, 32'h00000062, 1'b0, 1'b1);
`ifdef BSG_PAIR_GATHER_SLOT_CHECK_EN
    err_model = exp_err;
`else
    err_model = 1'b0;
`endif
    chk("t5_error_before", 64'(error_o), 64'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_error_set", 64'(error_o), 64'(err_model));
    chk("t5_pair_unchanged", data_o, 64'h00000062_00000061);
    repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_error_sticky", 64'(error_o), 64'(err_model));
    do_reset();
    chk("t5_error_cleared", 64'(error_o), 64'd0);

    // 6: random valid/yumi with well-formed slot pairs
    s = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, s, 1'($urandom_range(0, 1)));
      if (v_i && ready_o) s = ~s;
    end
    guard = 0;
    while ((exp_q.size() != 0 || v_o) && guard < 20) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      guard++;
    end
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t6_no_error", 64'(error_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
